// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares a single-port unified memory between the fetch (I) and
//            load/store (D) requesters with starvation-bounded D priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DEPTH        = 512,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_t;

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [31:0]      C_DEPTH = 32'(DEPTH);

  resp_t            r_owner, w_owner_nxt;
  logic             r_oor, w_oor_nxt;
  logic             r_load, w_load_nxt;
  logic [CNT_W-1:0] r_starve, w_starve_nxt;

  logic w_force_i, w_gnt_i, w_gnt_d, w_i_oor, w_d_oor;

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  assign w_force_i = i_req && (r_starve == C_LIMIT);
  assign w_gnt_d   = rst_n && d_req && !w_force_i;
  assign w_gnt_i   = rst_n && i_req && !w_gnt_d;
  assign w_i_oor   = (i_addr >= C_DEPTH);
  assign w_d_oor   = (d_addr >= C_DEPTH);

  assign i_gnt = w_gnt_i;
  assign d_gnt = w_gnt_d;

  always_comb begin
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    w_owner_nxt = RESP_NONE;
    w_oor_nxt   = 1'b0;
    w_load_nxt  = 1'b0;
    if (w_gnt_d) begin
      mem_addr    = d_addr;
      mem_wdata   = d_wdata;
      mem_write   = d_we && !w_d_oor;
      mem_read    = !d_we && !w_d_oor;
      w_owner_nxt = RESP_D;
      w_oor_nxt   = w_d_oor;
      w_load_nxt  = !d_we;
    end else if (w_gnt_i) begin
      mem_addr    = i_addr;
      mem_read    = !w_i_oor;
      w_owner_nxt = RESP_I;
      w_oor_nxt   = w_i_oor;
      w_load_nxt  = 1'b1;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!i_req || w_gnt_i) begin
      w_starve_nxt = '0;
    end else if (w_gnt_d && (r_starve != C_LIMIT)) begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= RESP_NONE;
      r_oor    <= 1'b0;
      r_load   <= 1'b0;
      r_starve <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_oor    <= w_oor_nxt;
      r_load   <= w_load_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign i_ack   = (r_owner == RESP_I);
  assign d_ack   = (r_owner == RESP_D);
  assign err     = (i_ack || d_ack) && r_oor;
  assign i_rdata = (i_ack && r_load && !r_oor) ? mem_rdata : 32'd0;
  assign d_rdata = (d_ack && r_load && !r_oor) ? mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
  logic        i_gnt, i_ack, d_gnt, d_ack, err, mem_write, mem_read;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem [0:511];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        err;
  } resp_t;
  resp_t sb[$];

  mem_port_arbiter #(.DEPTH(512), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data one cycle after mem_read, junk otherwise.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr[8:0]] : 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (i_ack && d_ack) begin
        chk("dual_ack", {i_ack, d_ack}, 2'b10);
      end else if (sb.size() == 0) begin
        chk("unexpected_ack", {i_ack, d_ack}, 2'b00);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("ack_port", {d_ack, i_ack}, e.is_d ? 2'b10 : 2'b01);
        chk("ack_data", e.is_d ? d_rdata : i_rdata, e.data);
        chk("ack_other_rdata", e.is_d ? i_rdata : d_rdata, 32'd0);
        chk("ack_err", err, e.err);
      end
    end else if (err) begin
      chk("err_without_ack", err, 1'b0);
    end
  end

  // One cycle of stimulus: entered just after a rising edge.
  task automatic cyc(input string nm,
                     input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dd,
                     input logic eig, input logic edg, input logic erd, input logic ewr,
                     input logic [31:0] eaddr, input logic [31:0] eresp, input logic eerr);
    resp_t r;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dd;
    @(negedge clk);
    chk({nm, "_gnt"}, {i_gnt, d_gnt, mem_read, mem_write}, {eig, edg, erd, ewr});
    if (eig || edg) chk({nm, "_addr"}, mem_addr, eaddr);
    if (edg && dwe) chk({nm, "_wdata"}, mem_wdata, dd);
    if (eig || edg) begin
      r.is_d = edg; r.data = eresp; r.err = eerr;
      sb.push_back(r);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [199:0] all_outs();
    return {i_gnt, i_ack, i_rdata, d_gnt, d_ack, d_rdata, err, mem_addr, mem_wdata, mem_write, mem_read};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'd0;
    mem[128] = 32'h8c030000;

    // Reset state with requests pending: nothing may be granted.
    i_req = 1; d_req = 1; i_addr = 128; d_addr = 6;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), 200'd0);
    rst_n = 1;
    i_req = 0; d_req = 0;

    // Fetch from 128
    cyc("fetch", 1, 128, 0, 0, 0, 0, 1, 0, 1, 0, 128, 32'h8c030000, 0);
    cyc("fetch_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Store then load back from 6
    cyc("store", 0, 0, 1, 1, 6, 32'h15, 0, 1, 0, 1, 6, 32'd0, 0);
    cyc("load", 0, 0, 1, 0, 6, 0, 0, 1, 1, 0, 6, 32'h15, 0);
    idle(1);

    // Starvation bound: four D grants, then I, then D again
    for (int k = 0; k < 4; k++)
      cyc("starve_d", 1, 128, 1, 0, 6, 0, 0, 1, 1, 0, 6, 32'h15, 0);
    cyc("starve_i", 1, 128, 1, 0, 6, 0, 1, 0, 1, 0, 128, 32'h8c030000, 0);
    cyc("after_i_d", 1, 128, 1, 0, 6, 0, 0, 1, 1, 0, 6, 32'h15, 0);
    cyc("only_i", 1, 128, 0, 0, 0, 0, 1, 0, 1, 0, 128, 32'h8c030000, 0);
    idle(1);

    // Out-of-range accesses (boundary and just below)
    cyc("oor_load", 0, 0, 1, 0, 512, 0, 0, 1, 0, 0, 512, 32'd0, 1);
    cyc("oor_store", 0, 0, 1, 1, 32'hFFFF_FFFF, 32'h77, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'd0, 1);
    cyc("oor_fetch", 1, 600, 0, 0, 0, 0, 1, 0, 0, 0, 600, 32'd0, 1);
    cyc("edge_load", 0, 0, 1, 0, 511, 0, 0, 1, 1, 0, 511, 32'd0, 0);
    idle(1);

    // Reset with a fetch response in flight: the ack must be discarded.
    i_req = 1; i_addr = 128;
    @(negedge clk);
    chk("inflight_gnt", i_gnt, 1'b1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("inflight_reset_outs", all_outs(), 200'd0);
    @(posedge clk); #1;
    chk("reset_hold_outs", all_outs(), 200'd0);
    i_req = 0;
    rst_n = 1;
    cyc("post_reset_fetch", 1, 128, 0, 0, 0, 0, 1, 0, 1, 0, 128, 32'h8c030000, 0);

    // Quiet period
    for (int k = 0; k < 10; k++) begin
      cyc("quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (k > 0) chk("quiet_ack", {i_ack, d_ack, err}, 3'b000);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
